// File: rtl/mux_scan_pkg.sv
// Shared types and default sizes for the mux scan controller.
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int unsigned MUX_WIDTH = 16;
    localparam int unsigned MUX_SEL_W = 4;

endpackage

// File: rtl/mux16_sel.sv
// WIDTH:1 single-bit mux; the only datapath driven by the scan controller.
module mux16_sel #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Serializes a latched word onto a valid/ready bit stream by stepping the select
// of a shared WIDTH:1 mux through the requested bit positions.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned WIDTH     = MUX_WIDTH,
    parameter int unsigned SEL_W     = $clog2(WIDTH),
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic [SEL_W:0]   in_len,
    input  logic             abort,
    output logic [SEL_W-1:0] sel,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done
);

    localparam int unsigned    LEN_W     = SEL_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
    localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(WIDTH - 1) : SEL_W'(0);

    scan_state_t      state;
    logic [WIDTH-1:0] word_q;
    logic [LEN_W-1:0] left;
    logic [LEN_W-1:0] len_eff_c;
    logic             fire_c;
    logic             last_c;

    // Zero and oversize lengths both mean a full word.
    always_comb begin
        len_eff_c = in_len;
        if ((in_len == LEN_W'(0)) || (in_len > LEN_MAX)) begin
            len_eff_c = LEN_MAX;
        end
    end

    assign in_ready = (state == IDLE) & ~rst;
    assign fire_c   = out_valid & out_ready;
    assign last_c   = (left == LEN_W'(1));

    // Final handshake beats abort; a non-final handshake still advances before cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= SEL_W'(0);
            word_q    <= '0;
            left      <= LEN_W'(0);
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        word_q    <= in_word;
                        left      <= len_eff_c;
                        sel       <= SEL_FIRST;
                        out_valid <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (fire_c && last_c) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        if (fire_c) begin
                            sel  <= MSB_FIRST ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));
                            left <= left - LEN_W'(1);
                        end
                        if (abort) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    mux16_sel #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_mux (
        .in  (word_q),
        .sel (sel),
        .out (out_bit)
    );

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: LSB-first and MSB-first instances share stimulus.
module tb_mux_scan_ctrl;

    typedef struct packed {
        logic [3:0] sel;
        logic       b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_l;
    logic        in_valid_m;
    logic        abort;
    logic        out_ready;
    logic [15:0] in_word;
    logic [4:0]  in_len;

    logic        in_ready_l, out_bit_l, out_valid_l, done_l;
    logic [3:0]  sel_l;
    logic        in_ready_m, out_bit_m, out_valid_m, done_m;
    logic [3:0]  sel_m;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l),
        .in_word(in_word), .in_len(in_len), .abort(abort), .sel(sel_l),
        .out_bit(out_bit_l), .out_valid(out_valid_l), .out_ready(out_ready), .done(done_l)
    );

    mux_scan_ctrl #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid_m), .in_ready(in_ready_m),
        .in_word(in_word), .in_len(in_len), .abort(abort), .sel(sel_m),
        .out_bit(out_bit_m), .out_valid(out_valid_m), .out_ready(out_ready), .done(done_m)
    );

    task automatic test_reset();
        rst = 1'b1; in_valid_l = 1'b0; in_valid_m = 1'b0; abort = 1'b0;
        out_ready = 1'b0; in_word = 16'h0; in_len = 5'd0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (in_ready_l !== 1'b0 || in_ready_m !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready_l, in_ready_m);
            end
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready_l, sel_l, out_valid_l, done_l} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle_lsb: got rdy=%b sel=%0d v=%b d=%b want 1 0 0 0",
                     in_ready_l, sel_l, out_valid_l, done_l);
        end
        vectors++;
        if ({in_ready_m, sel_m, out_valid_m, done_m} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle_msb: got rdy=%b sel=%0d v=%b d=%b want 1 0 0 0",
                     in_ready_m, sel_m, out_valid_m, done_m);
        end
    endtask

    task automatic test_lsb_full();
        logic [15:0] w = 16'hA5C3;
        exp_t e;
        int   dones = 0;
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back({4'(i), w[i]});
        in_word = w; in_len = 5'd0; out_ready = 1'b1; in_valid_l = 1'b1;
        @(negedge clk);
        in_valid_l = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid_l) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_extra_bit: got bit at cycle %0d want none", c);
                end else begin
                    e = q.pop_front();
                    if (out_bit_l !== e.b || sel_l !== e.sel) begin
                        errors++;
                        $display("FAIL lsb_bit: got sel=%0d bit=%b want sel=%0d bit=%b",
                                 sel_l, out_bit_l, e.sel, e.b);
                    end
                end
            end
            if (done_l === 1'b1) begin
                dones++;
                vectors++;
                if (c != 17) begin
                    errors++;
                    $display("FAIL lsb_done_cycle: got %0d want 17", c);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (dones != 1 || q.size() != 0) begin
            errors++;
            $display("FAIL lsb_totals: got done=%0d left=%0d want 1 0", dones, q.size());
        end
    endtask

    task automatic test_msb_short();
        logic [15:0] w = 16'h8001;
        exp_t e;
        int   dones = 0;
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back({4'(15 - i), w[15 - i]});
        in_word = w; in_len = 5'd3; out_ready = 1'b1; in_valid_m = 1'b1;
        @(negedge clk);
        in_valid_m = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (out_valid_m) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL msb_extra_bit: got sel=%0d at cycle %0d want none", sel_m, c);
                end else begin
                    e = q.pop_front();
                    if (out_bit_m !== e.b || sel_m !== e.sel) begin
                        errors++;
                        $display("FAIL msb_bit: got sel=%0d bit=%b want sel=%0d bit=%b",
                                 sel_m, out_bit_m, e.sel, e.b);
                    end
                end
            end
            if (done_m === 1'b1) begin
                dones++;
                vectors++;
                if (c != 4) begin
                    errors++;
                    $display("FAIL msb_done_cycle: got %0d want 4", c);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (dones != 1 || q.size() != 0 || out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL msb_totals: got done=%0d left=%0d v=%b want 1 0 0",
                     dones, q.size(), out_valid_m);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] w = 16'h00FF;
        exp_t e;
        int   dones = 0, ones = 0;
        logic prev_stall = 1'b0;
        logic [3:0] psel = 4'd0;
        logic pbit = 1'b0;
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back({4'(i), w[i]});
        in_word = w; in_len = 5'd8; out_ready = 1'b0; in_valid_l = 1'b1;
        @(negedge clk);
        in_valid_l = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            out_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
            if (prev_stall) begin
                vectors++;
                if (out_valid_l !== 1'b1 || sel_l !== psel || out_bit_l !== pbit) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b sel=%0d bit=%b want 1 %0d %b",
                             out_valid_l, sel_l, out_bit_l, psel, pbit);
                end
            end
            if (out_valid_l && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_bit: got sel=%0d want none", sel_l);
                end else begin
                    e = q.pop_front();
                    if (out_bit_l !== e.b || sel_l !== e.sel) begin
                        errors++;
                        $display("FAIL bp_bit: got sel=%0d bit=%b want sel=%0d bit=%b",
                                 sel_l, out_bit_l, e.sel, e.b);
                    end
                    if (out_bit_l === 1'b1) ones++;
                end
            end
            if (done_l === 1'b1) dones++;
            prev_stall = out_valid_l && !out_ready;
            psel = sel_l;
            pbit = out_bit_l;
            @(negedge clk);
        end
        out_ready = 1'b1;
        vectors++;
        if (dones != 1 || ones != 8 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_totals: got done=%0d ones=%0d left=%0d want 1 8 0",
                     dones, ones, q.size());
        end
    endtask

    task automatic test_abort_mid();
        logic [15:0] w = 16'h1234;
        exp_t e;
        q.delete();
        for (int i = 0; i < 2; i++) q.push_back({4'(i), w[i]});
        in_word = w; in_len = 5'd8; out_ready = 1'b1; in_valid_l = 1'b1;
        @(negedge clk);
        in_valid_l = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            out_ready = (c <= 2);
            abort = (c == 3);
            if (c <= 3) begin
                vectors++;
                if (out_valid_l !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_pre_valid: got %b want 1 at cycle %0d", out_valid_l, c);
                end
                if (c <= 2 && q.size() != 0) begin
                    e = q.pop_front();
                    vectors++;
                    if (out_bit_l !== e.b || sel_l !== e.sel) begin
                        errors++;
                        $display("FAIL abort_bit: got sel=%0d bit=%b want sel=%0d bit=%b",
                                 sel_l, out_bit_l, e.sel, e.b);
                    end
                end
            end else begin
                vectors++;
                if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1 || done_l !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle: got v=%b rdy=%b done=%b want 0 1 0",
                             out_valid_l, in_ready_l, done_l);
                end
            end
            @(negedge clk);
        end
        abort = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_abort_final();
        in_word = 16'h0002; in_len = 5'd2; out_ready = 1'b1; in_valid_l = 1'b1;
        @(negedge clk);
        in_valid_l = 1'b0;
        vectors++;
        if (out_bit_l !== 1'b0 || sel_l !== 4'd0) begin
            errors++;
            $display("FAIL absf_bit0: got sel=%0d bit=%b want 0 0", sel_l, out_bit_l);
        end
        @(negedge clk);
        abort = 1'b1;
        vectors++;
        if (out_bit_l !== 1'b1 || sel_l !== 4'd1) begin
            errors++;
            $display("FAIL absf_bit1: got sel=%0d bit=%b want 1 1", sel_l, out_bit_l);
        end
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (done_l !== 1'b1 || out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL absf_done: got done=%b v=%b rdy=%b want 1 0 1",
                     done_l, out_valid_l, in_ready_l);
        end
        @(negedge clk);
        vectors++;
        if (done_l !== 1'b0) begin
            errors++;
            $display("FAIL absf_done_pulse: got %b want 0", done_l);
        end
    endtask

    task automatic test_len_sat();
        int fires = 0, done_at = 0;
        in_word = 16'hFFFF; in_len = 5'd20; out_ready = 1'b1; in_valid_l = 1'b1;
        @(negedge clk);
        in_valid_l = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (out_valid_l) fires++;
            if (done_l === 1'b1) done_at = c;
            @(negedge clk);
        end
        vectors++;
        if (fires != 16 || done_at != 17) begin
            errors++;
            $display("FAIL len_sat: got bits=%0d done_at=%0d want 16 17", fires, done_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w1 = 16'hBEEF;
        logic [15:0] w2 = 16'h1357;
        exp_t e;
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back({4'(i), w1[i]});
        in_word = w1; in_len = 5'd4; out_ready = 1'b1; in_valid_l = 1'b1;
        @(negedge clk);
        in_word = w2; in_len = 5'd5;
        for (int c = 1; c <= 4; c++) begin
            vectors++;
            if (out_valid_l !== 1'b1 || q.size() == 0) begin
                errors++;
                $display("FAIL b2b_first_valid: got v=%b want 1 at cycle %0d", out_valid_l, c);
            end else begin
                e = q.pop_front();
                if (out_bit_l !== e.b || sel_l !== e.sel) begin
                    errors++;
                    $display("FAIL b2b_first_bit: got sel=%0d bit=%b want sel=%0d bit=%b",
                             sel_l, out_bit_l, e.sel, e.b);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (done_l !== 1'b1 || in_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_accept: got done=%b rdy=%b want 1 1", done_l, in_ready_l);
        end
        for (int i = 0; i < 2; i++) q.push_back({4'(i), w2[i]});
        @(negedge clk);
        in_valid_l = 1'b0;
        for (int c = 0; c < 2; c++) begin
            e = q.pop_front();
            vectors++;
            if (out_valid_l !== 1'b1 || out_bit_l !== e.b || sel_l !== e.sel) begin
                errors++;
                $display("FAIL b2b_second_bit: got v=%b sel=%0d bit=%b want 1 %0d %b",
                         out_valid_l, sel_l, out_bit_l, e.sel, e.b);
            end
            if (c == 1) rst = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if ({in_ready_l, sel_l, out_valid_l, done_l} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midscan_reset: got rdy=%b sel=%0d v=%b d=%b want 0 0 0 0",
                     in_ready_l, sel_l, out_valid_l, done_l);
        end
        rst = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0 || done_l !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got rdy=%b v=%b d=%b want 1 0 0",
                         in_ready_l, out_valid_l, done_l);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lsb_full();
        test_msb_short();
        test_backpressure();
        test_abort_mid();
        test_abort_final();
        test_len_sat();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
